adc_scheduler: RTL

//  Round-robin sequencer that time-shares the single successive-approximation ADC between NCH

---
 rtl/adc_scheduler_pkg.sv | 22 ++
 rtl/adc_scheduler_cycle_counter.sv | 36 +++
 rtl/adc_scheduler.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/adc_scheduler_pkg.sv
// Shared definitions for the ADC round-robin scheduler: FSM encodings, default
// converter timing constants and a counter-width helper.
package adc_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_START   = 3'd2,
    S_CONVERT = 3'd3,
    S_STORE   = 3'd4
  } state_t;

  localparam int DEF_DW      = 7;
  localparam int DEF_SETTLE  = 16;
  localparam int DEF_TIMEOUT = 255;

  // Bits needed to hold max_val; never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/adc_scheduler_cycle_counter.sv
// Loadable down-counter with zero flag; used for the mux-settle and the
// conversion-timeout intervals. Load has priority over decrement.
module adc_scheduler_cycle_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/adc_scheduler.sv
// Round-robin sequencer sharing one SAR ADC across NCH mux inputs and latching
// per-channel results. Define ADC_AVG_EN for rounded 2-tap averaging on store.
module adc_scheduler
  import adc_scheduler_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int SELW    = 2,
  parameter int DW      = DEF_DW,
  parameter int SETTLE  = DEF_SETTLE,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Enable,
  output logic              ADCstart,
  input  logic              ADCdone,
  input  logic [DW-1:0]     ADCdata,
  output logic [SELW-1:0]   MuxSel,
  output logic [NCH*DW-1:0] ChanData,
  output logic [NCH-1:0]    ChanValid,
  output logic              TimeoutErr,
  output state_t            DbgState
);

  localparam int SW = cnt_width(SETTLE - 1);
  localparam int TW = cnt_width(TIMEOUT - 1);

  // ADC protocol: ADCstart is a single-cycle request issued from START; the
  // converter answers with ADCdone (data valid in that same cycle). ADCdone is
  // only honoured in CONVERT, so stale or early pulses are dropped.

  state_t              state_q;
  logic [SELW-1:0]     ptr_q;
  logic [SELW-1:0]     ptr_nx;
  logic [SELW-1:0]     mux_q;
  logic                start_q;
  logic [DW-1:0]       data_q;
  logic [NCH*DW-1:0]   chan_q;
  logic [NCH*DW-1:0]   chan_d;
  logic [NCH-1:0]      valid_q;
  logic [NCH-1:0]      valid_d;
  logic                terr_q;
  logic [DW-1:0]       store_w;

  logic settle_load;
  logic settle_dec;
  logic settle_zero;
  logic tmo_load;
  logic tmo_dec;
  logic tmo_zero;

  always_comb begin
    ptr_nx = (ptr_q == SELW'(NCH - 1)) ? '0 : ptr_q + SELW'(1);
  end

  // Settle reloads on every entry into SETTLE; timeout reloads leaving START.
  always_comb begin
    settle_load = Enable && ((state_q == S_IDLE) || (state_q == S_STORE) ||
                  ((state_q == S_CONVERT) && !ADCdone && tmo_zero));
    settle_dec  = (state_q == S_SETTLE) && !settle_zero;
    tmo_load    = (state_q == S_START);
    tmo_dec     = (state_q == S_CONVERT) && !tmo_zero;
  end

  adc_scheduler_cycle_counter #(.W(SW)) u_settle_cnt (
    .clk_i      (CLK),
    .rst_i      (Reset),
    .load_i     (settle_load),
    .load_val_i (SW'(SETTLE - 1)),
    .dec_i      (settle_dec),
    .zero_o     (settle_zero)
  );

  adc_scheduler_cycle_counter #(.W(TW)) u_timeout_cnt (
    .clk_i      (CLK),
    .rst_i      (Reset),
    .load_i     (tmo_load),
    .load_val_i (TW'(TIMEOUT - 1)),
    .dec_i      (tmo_dec),
    .zero_o     (tmo_zero)
  );

`ifdef ADC_AVG_EN
  logic [NCH-1:0] seen_q;
  logic           seen_w;
  logic [DW-1:0]  old_w;
  logic [DW:0]    sum_w;

  always_comb begin
    seen_w = 1'b0;
    old_w  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ptr_q == SELW'(k)) begin
        seen_w = seen_q[k];
        old_w  = chan_q[k*DW +: DW];
      end
    end
  end

  // Sum kept at DW+1 bits so the rounding carry is not lost before the shift.
  assign sum_w   = {1'b0, old_w} + {1'b0, data_q} + (DW+1)'(1);
  assign store_w = seen_w ? DW'(sum_w >> 1) : data_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      seen_q <= '0;
    end else if (state_q == S_STORE) begin
      seen_q <= seen_q | valid_d;
    end
  end
`else
  assign store_w = data_q;
`endif

  always_comb begin
    chan_d  = chan_q;
    valid_d = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ptr_q == SELW'(k)) begin
        chan_d[k*DW +: DW] = store_w;
        valid_d[k]         = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      mux_q   <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (Enable) begin
            mux_q   <= ptr_q;
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (!Enable) begin
            state_q <= S_IDLE;
          end else if (settle_zero) begin
            start_q <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          state_q <= S_CONVERT;
        end
        S_CONVERT: begin
          if (ADCdone) begin
            data_q  <= ADCdata;
            state_q <= S_STORE;
          end else if (tmo_zero) begin
            // Abandoned conversion: keep old data, move on to the next channel.
            terr_q <= 1'b1;
            ptr_q  <= ptr_nx;
            if (Enable) begin
              mux_q   <= ptr_nx;
              state_q <= S_SETTLE;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_STORE: begin
          chan_q  <= chan_d;
          valid_q <= valid_d;
          ptr_q   <= ptr_nx;
          if (Enable) begin
            mux_q   <= ptr_nx;
            state_q <= S_SETTLE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ADCstart   = start_q;
  assign MuxSel     = mux_q;
  assign ChanData   = chan_q;
  assign ChanValid  = valid_q;
  assign TimeoutErr = terr_q;
  assign DbgState   = state_q;

endmodule
